bin2bcd_seq: RTL and testbench
==============================

Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter that sits directly upstream of the 4-digit 7-segment display stage.
- Takes an unsigned binary count and produces a registered 16-bit packed BCD word (4 nibbles, [15:12] = thousands ... [3:0] = units).
- The display consumes that word directly; the word is held stable between conversions so the display never sees intermediate values.
- Uses iterative double-dabble (shift-and-add-3), one bit per clock, to keep area small.

Parameters:
- BIN_W, 14, width of binary input; legal range 1..16.

Ports:
- CLK  input  1  system clock, rising-edge.
- RST  input  1  synchronous reset, active-high.
- IN_VALID  input  1  BIN_IN is valid; accepted when IN_VALID && IN_READY at a rising edge.
- BIN_IN  input  BIN_W  unsigned binary value to convert.
- IN_READY  output  1  converter idle and able to accept.
- BCD_OUT  output  16  packed 4-digit BCD result; connects to the display data input.
- OUT_VALID  output  1  one-cycle pulse; BCD_OUT updated this cycle.
- OVF  output  1  last accepted value was > 9999; held with BCD_OUT.

Behaviour:
- Clock and reset: single clock CLK; RST is synchronous and active-high, sampled only on the rising edge of CLK.
- Reset values: BCD_OUT = 16'h0000, OUT_VALID = 0, OVF = 0, IN_READY = 1, state IDLE, shift counter 0, scratch registers 0.
- States:
  - IDLE: IN_READY = 1. On accept, latch BIN_IN into the shift register, clear the 20-bit BCD scratch (5 digits), set counter = 0, go to CONV.
  - CONV: IN_READY = 0. Each edge: every scratch digit >= 5 gets +3, then {scratch, shift} shifts left 1 and counter increments.
  - After the edge on which counter reaches BIN_W-1 (the BIN_W-th shift): register the result into BCD_OUT/OVF, pulse OUT_VALID, return to IDLE.
- Latency: accept at edge e0 -> BCD_OUT valid and OUT_VALID = 1 immediately after edge e(BIN_W), i.e. 14 clocks at the default. OUT_VALID is high for exactly one cycle.
- Back-to-back: IN_READY is high in the same cycle as OUT_VALID, so a new value can be accepted on the next edge. Throughput is one conversion per BIN_W+1 clocks.
- IN_VALID while IN_READY = 0: ignored, not queued; BIN_IN changes during CONV have no effect.
- BCD_OUT and OVF change only in the OUT_VALID cycle (or on reset); otherwise they hold the last result indefinitely.
- OVF = 1 iff the 5th scratch digit (ten-thousands) is nonzero, i.e. value > 9999. This is independent of the optional feature.
- Width rules:
  - The scratch is always 5 digits, which is sufficient for 65535.
  - For BIN_W <= 13 the value cannot exceed 9999, so OVF stays 0.
  - BIN_IN is treated as unsigned; no sign handling.
- Reset mid-CONV: conversion aborted, no OUT_VALID, all outputs return to reset values on that edge.
- RST and IN_VALID in the same cycle: reset wins; the input is not accepted.

Optional Feature:
- Macro: BIN2BCD_SAT_EN
- Defined: when OVF = 1, BCD_OUT is forced to 16'h9999 (the display saturates).
- Not defined: BCD_OUT = low 4 scratch digits, i.e. value mod 10000 in BCD.
- OVF behaves identically in both builds.

Test Plan:
- Reset, then BIN_IN = 1234 with IN_VALID one cycle -> IN_READY low for 14 cycles; OUT_VALID pulse 14 clocks after accept; BCD_OUT = 16'h1234, OVF = 0.
- Boundary values 0 and 9999 -> BCD_OUT = 16'h0000 and 16'h9999 respectively, OVF = 0 in both.
- BIN_IN = 12345 -> OVF = 1; BCD_OUT = 16'h9999 with BIN2BCD_SAT_EN defined, 16'h2345 without. BIN_IN = 16383 -> OVF = 1; 16'h9999 / 16'h6383.
- IN_VALID held continuously, alternating 42 and 7001 -> results 16'h0042 and 16'h7001; a new accept occurs every 15 clocks. A value presented mid-CONV is not converted.
- RST asserted 5 cycles into a conversion of 5678 -> no OUT_VALID; BCD_OUT = 16'h0000 and IN_READY = 1 on the next cycle. A later conversion of 5678 gives 16'h5678.
- Hold check: after converting 0321, keep IN_VALID low for 100 cycles -> BCD_OUT stays 16'h0321 and OUT_VALID stays 0 throughout.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one input bit per clock.
// Define BIN2BCD_SAT_EN to saturate BCD_OUT at 16'h9999 when the value exceeds 9999.
module bin2bcd_seq #(
    parameter int unsigned BIN_W = 14
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    input  logic [BIN_W-1:0] BIN_IN,
    output logic             IN_READY,
    output logic [15:0]      BCD_OUT,
    output logic             OUT_VALID,
    output logic             OVF
);

    localparam int unsigned CntW = 5;
    localparam logic [CntW-1:0] LastCnt = CntW'(BIN_W - 1);

    typedef enum logic [0:0] {StIdle, StConv} state_e;

    state_e           state_q, state_d;
    logic [BIN_W-1:0] shift_q, shift_d;
    logic [19:0]      scratch_q, scratch_d;
    logic [19:0]      scratch_adj, scratch_sh;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [15:0]      bcd_q, bcd_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;

    // Add-3 correction on every digit, then shift in the next binary MSB.
    always_comb begin
        scratch_adj = scratch_q;
        for (int i = 0; i < 5; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
        scratch_sh = {scratch_adj[18:0], shift_q[BIN_W-1]};
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        valid_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (IN_VALID) begin
                    shift_d   = BIN_IN;
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = StConv;
                end
            end
            StConv: begin
                shift_d   = shift_q << 1;
                scratch_d = scratch_sh;
                cnt_d     = cnt_q + CntW'(1);
                // Final shift: publish the just-shifted scratch directly.
                if (cnt_q == LastCnt) begin
                    state_d = StIdle;
                    valid_d = 1'b1;
                    ovf_d   = |scratch_sh[19:16];
`ifdef BIN2BCD_SAT_EN
                    bcd_d   = ovf_d ? 16'h9999 : scratch_sh[15:0];
`else
                    bcd_d   = scratch_sh[15:0];
`endif
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
        end
    end

    assign IN_READY  = (state_q == StIdle);
    assign BCD_OUT   = bcd_q;
    assign OUT_VALID = valid_q;
    assign OVF       = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: decimal-arithmetic reference model, randomized values.
module tb_bin2bcd_seq;

    localparam int unsigned BW = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [BW-1:0] bin_in;
    logic          in_ready;
    logic [15:0]   bcd_out;
    logic          out_valid;
    logic          ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.BIN_W(BW)) dut (
        .CLK       (clk),
        .RST       (rst),
        .IN_VALID  (in_valid),
        .BIN_IN    (bin_in),
        .IN_READY  (in_ready),
        .BCD_OUT   (bcd_out),
        .OUT_VALID (out_valid),
        .OVF       (ovf)
    );

    function automatic logic [15:0] ref_bcd(input int unsigned v);
        int unsigned m;
        m = v % 10000;
`ifdef BIN2BCD_SAT_EN
        if (v > 9999) m = 9999;
`endif
        return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    function automatic logic ref_ovf(input int unsigned v);
        return v > 9999;
    endfunction

    // Called at a falling edge; returns one falling edge after the accepting edge.
    task automatic start(input int unsigned v, output bit was_ready);
        was_ready = (in_ready === 1'b1);
        in_valid  = 1'b1;
        bin_in    = BW'(v);
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    task automatic wait_done(input bit noise, output int cyc, output bit ready_low);
        cyc       = 0;
        ready_low = 1'b1;
        while (out_valid !== 1'b1 && cyc < 40) begin
            if (in_ready !== 1'b0) ready_low = 1'b0;
            if (noise) begin
                in_valid = 1'($urandom);
                bin_in   = BW'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
    endtask

    task automatic convert(input int unsigned v, input bit noise, output bit was_ready,
                           output int cyc, output bit ready_low, output logic [15:0] bcd,
                           output logic ov, output logic rdy_done);
        start(v, was_ready);
        wait_done(noise, cyc, ready_low);
        bcd      = bcd_out;
        ov       = ovf;
        rdy_done = in_ready;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b1;
        bin_in   = BW'(1234);
        repeat (3) @(negedge clk);
        checks++;
        if (bcd_out !== 16'h0000 || out_valid !== 1'b0 || ovf !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_values: bcd=%h ov=%b ovf=%b rdy=%b, want 0000 0 0 1",
                     bcd_out, out_valid, ovf, in_ready);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_wins: rdy=%b ov=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic check_one(input string name, input int unsigned v, input bit noise);
        bit          was_ready, ready_low;
        int          cyc;
        logic [15:0] bcd;
        logic        ov, rdy_done;
        convert(v, noise, was_ready, cyc, ready_low, bcd, ov, rdy_done);
        checks++;
        if (!was_ready || cyc != 14 || !ready_low || rdy_done !== 1'b1) begin
            errors++;
            $display("FAIL %s_timing v=%0d: ready=%b cycles=%0d busy_low=%b rdy_at_done=%b, want 1 14 1 1",
                     name, v, was_ready, cyc, ready_low, rdy_done);
        end
        checks++;
        if (bcd !== ref_bcd(v)) begin
            errors++;
            $display("FAIL %s_bcd v=%0d: got %h want %h", name, v, bcd, ref_bcd(v));
        end
        checks++;
        if (ov !== ref_ovf(v)) begin
            errors++;
            $display("FAIL %s_ovf v=%0d: got %b want %b", name, v, ov, ref_ovf(v));
        end
        checks++;
        if (out_valid !== 1'b0 || bcd_out !== ref_bcd(v)) begin
            errors++;
            $display("FAIL %s_pulse v=%0d: ov=%b bcd=%h, want 0 %h", name, v, out_valid, bcd_out,
                     ref_bcd(v));
        end
    endtask

    task automatic test_directed();
        int unsigned vals[6] = '{1234, 12345, 0, 16383, 9999, 1234};
        foreach (vals[i]) check_one("directed", vals[i], 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 15; i++) check_one("random", $urandom_range(0, 16383), 1'b1);
    endtask

    task automatic test_back_to_back();
        int unsigned q[$];
        int unsigned exp;
        int          last_acc = -1;
        int          n_res = 0;
        int          k;
        bit          sel = 1'b0;
        in_valid = 1'b1;
        for (int t = 0; t < 80; t++) begin
            if (out_valid === 1'b1) begin
                checks++;
                exp = (q.size() > 0) ? q.pop_front() : 32'hFFFF;
                if (bcd_out !== ref_bcd(exp)) begin
                    errors++;
                    $display("FAIL b2b_result t=%0d: got %h want %h", t, bcd_out, ref_bcd(exp));
                end
                n_res++;
            end
            if (in_ready === 1'b1) begin
                bin_in = sel ? BW'(7001) : BW'(42);
                sel    = ~sel;
                q.push_back(int'(bin_in));
                if (last_acc >= 0) begin
                    checks++;
                    if (t - last_acc != 15) begin
                        errors++;
                        $display("FAIL b2b_spacing t=%0d: got %0d want 15", t, t - last_acc);
                    end
                end
                last_acc = t;
            end else begin
                bin_in = BW'($urandom);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        k = 0;
        while (out_valid !== 1'b1 && k < 30) begin
            @(negedge clk);
            k++;
        end
        checks++;
        exp = (q.size() > 0) ? q.pop_front() : 32'hFFFF;
        if (out_valid !== 1'b1 || bcd_out !== ref_bcd(exp)) begin
            errors++;
            $display("FAIL b2b_drain: ov=%b bcd=%h want 1 %h", out_valid, bcd_out, ref_bcd(exp));
        end
        @(negedge clk);
        checks++;
        if (n_res != 5) begin
            errors++;
            $display("FAIL b2b_count: got %0d results want 5", n_res);
        end
    endtask

    task automatic test_reset_mid();
        bit was_ready;
        bit saw_valid = 1'b0;
        start(5678, was_ready);
        for (int c = 0; c < 5; c++) begin
            if (out_valid === 1'b1) saw_valid = 1'b1;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (saw_valid || out_valid !== 1'b0 || bcd_out !== 16'h0000 || ovf !== 1'b0
            || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: early=%b ov=%b bcd=%h ovf=%b rdy=%b, want 0 0 0000 0 1",
                     saw_valid, out_valid, bcd_out, ovf, in_ready);
        end
        for (int c = 0; c < 20; c++) begin
            if (out_valid === 1'b1) saw_valid = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (saw_valid) begin
            errors++;
            $display("FAIL reset_mid_abort: got OUT_VALID=1 want 0 after reset");
        end
        check_one("after_reset", 5678, 1'b0);
    endtask

    task automatic test_hold();
        int bad = 0;
        check_one("hold_setup", 321, 1'b0);
        for (int c = 0; c < 100; c++) begin
            bin_in = BW'($urandom);
            @(negedge clk);
            if (bcd_out !== 16'h0321 || out_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold: %0d cycles changed (last bcd=%h ov=%b), want 0321 0", bad,
                     bcd_out, out_valid);
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        bin_in   = '0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
